// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : alu_pkg                                                    |
// | Shared ALU opcode encodings and the shifter mode type.               |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package alu_pkg;

  // Opcode width shared by the logic slice, the adder slice and the decoder
  localparam int ALU_OP_W = 5;

  localparam logic [ALU_OP_W-1:0] OP_AND  = 5'b00001;
  localparam logic [ALU_OP_W-1:0] OP_OR   = 5'b00010;
  localparam logic [ALU_OP_W-1:0] OP_NOT  = 5'b00011;
  localparam logic [ALU_OP_W-1:0] OP_XOR  = 5'b00100;
  localparam logic [ALU_OP_W-1:0] OP_NAND = 5'b00101;
  localparam logic [ALU_OP_W-1:0] OP_NOR  = 5'b00110;
  localparam logic [ALU_OP_W-1:0] OP_SRL  = 5'b00111;
  localparam logic [ALU_OP_W-1:0] OP_SRA  = 5'b01000;
  localparam logic [ALU_OP_W-1:0] OP_SLL  = 5'b01001;
  localparam logic [ALU_OP_W-1:0] OP_EQ   = 5'b01010;
  localparam logic [ALU_OP_W-1:0] OP_GT   = 5'b01011;
  localparam logic [ALU_OP_W-1:0] OP_LT   = 5'b01100;

  // Shift direction/fill selection for the shifter
  typedef enum logic [1:0] {
    SH_SRL = 2'd0,
    SH_SRA = 2'd1,
    SH_SLL = 2'd2
  } shift_mode_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/logic_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : logic_shifter                                              |
// | Combinational logical/arithmetic right and logical left shifter.     |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module logic_shifter
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [SHW-1:0]   i_shamt,
  input  shift_mode_e      i_mode,
  output logic [WIDTH-1:0] o_result
);

  // Select the shift flavour; SRA replicates the operand MSB into vacated bits
  always_comb begin
    o_result = '0;
    case (i_mode)
      SH_SRL:  o_result = i_a >> i_shamt;
      SH_SRA:  o_result = $unsigned($signed(i_a) >>> i_shamt);
      SH_SLL:  o_result = i_a << i_shamt;
      default: o_result = '0;
    endcase
  end

endmodule : logic_shifter
`default_nettype wire

// File: rtl/module_logic_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : module_logic_alu                                           |
// | Registered logic / shift / compare slice of the ALU, 1-cycle latency.|
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module module_logic_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_valid,
  input  logic [WIDTH-1:0]    alu_a,
  input  logic [WIDTH-1:0]    alu_b,
  input  logic [ALU_OP_W-1:0] alu_op,
  output logic [WIDTH-1:0]    alu_result,
  output logic                result_valid
);

  localparam int SHW = $clog2(WIDTH);

  shift_mode_e      w_shift_mode;
  logic [WIDTH-1:0] w_shift_res;
  logic [WIDTH-1:0] w_next_result;
  logic [WIDTH-1:0] r_result;
  logic             r_valid;

  // Only the low SHW bits of B act as the shift amount
  assign w_shift_mode = (alu_op == OP_SRA) ? SH_SRA :
                        (alu_op == OP_SLL) ? SH_SLL : SH_SRL;

  logic_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .i_a      (alu_a),
    .i_shamt  (alu_b[SHW-1:0]),
    .i_mode   (w_shift_mode),
    .o_result (w_shift_res)
  );

  // Opcode decode; undefined codes resolve to zero, compares zero-extend the flag
  always_comb begin
    w_next_result = '0;
    case (alu_op)
      OP_AND:  w_next_result = alu_a & alu_b;
      OP_OR:   w_next_result = alu_a | alu_b;
      OP_NOT:  w_next_result = ~alu_a;
      OP_XOR:  w_next_result = alu_a ^ alu_b;
      OP_NAND: w_next_result = ~(alu_a & alu_b);
      OP_NOR:  w_next_result = ~(alu_a | alu_b);
      OP_SRL,
      OP_SRA,
      OP_SLL:  w_next_result = w_shift_res;
      OP_EQ:   w_next_result = {{(WIDTH-1){1'b0}}, (alu_a == alu_b)};
      OP_GT:   w_next_result = {{(WIDTH-1){1'b0}}, (alu_a >  alu_b)};
      OP_LT:   w_next_result = {{(WIDTH-1){1'b0}}, (alu_a <  alu_b)};
      default: w_next_result = '0;
    endcase
  end

  // Result register: load on valid, otherwise hold; valid flag is a one-cycle echo
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= alu_valid;
      if (alu_valid) begin
        r_result <= w_next_result;
      end
    end
  end

  assign alu_result   = r_result;
  assign result_valid = r_valid;

endmodule : module_logic_alu
`default_nettype wire

// File: tb/tb_module_logic_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_module_logic_alu                                        |
// | Self-checking bench for the logic/shift/compare ALU slice.           |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module tb_module_logic_alu;

  localparam int WIDTH = 32;

  typedef struct {
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic             alu_valid;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [4:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             result_valid;

  logic [WIDTH-1:0] exp_q[$];
  int               n_vec;
  int               n_err;

  module_logic_alu #(
    .WIDTH (WIDTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (alu_valid),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one valid op at a falling edge and record its expected result
  task automatic issue(input logic [4:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp);
    alu_valid = 1'b1;
    alu_op    = op;
    alu_a     = a;
    alu_b     = b;
    exp_q.push_back(exp);
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    alu_op    = 5'b00000;
    alu_a     = '0;
    alu_b     = '0;
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] e;
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(5'b00010, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678);
    @(negedge clk);
    e = exp_q.pop_front();
    n_vec++;
    if (alu_result !== e || result_valid !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_or: got %h/%b want %h/1", alu_result, result_valid, e);
    end
    // Pending op then asynchronous reset mid-cycle: outputs clear without an edge
    issue(5'b00001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    void'(exp_q.pop_back());
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (alu_result !== '0 || result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got %h/%b want 00000000/0", alu_result, result_valid);
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (alu_result !== '0 || result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got %h/%b want 00000000/0", alu_result, result_valid);
    end
  endtask

  task automatic run_table(input string name, input vec_t tbl[]);
    logic [WIDTH-1:0] e;
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if (alu_result !== e || result_valid !== 1'b1) begin
        n_err++;
        $display("FAIL %s[%0d] op=%b a=%h b=%h: got %h/%b want %h/1",
                 name, i, tbl[i].op, tbl[i].a, tbl[i].b, alu_result, result_valid, e);
      end
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_bitwise();
    vec_t t[] = '{
      '{5'b00001, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'hAAAA_0000},
      '{5'b00010, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'hFFFF_AAAA},
      '{5'b00101, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_FFFF},
      '{5'b00110, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'h0000_5555},
      '{5'b00011, 32'hF0F0_F0F0, 32'hDEAD_BEEF, 32'h0F0F_0F0F},
      '{5'b00100, 32'h1234_5678, 32'h8765_4321, 32'h9551_1559}
    };
    run_table("bitwise", t);
  endtask

  task automatic test_shift();
    vec_t t[] = '{
      '{5'b01001, 32'h0000_000F, 32'd4,  32'h0000_00F0},
      '{5'b00111, 32'hF000_0000, 32'd4,  32'h0F00_0000},
      '{5'b01000, 32'h7000_0000, 32'd4,  32'h0700_0000},
      '{5'b01000, 32'hFFFF_FF00, 32'd4,  32'hFFFF_FFF0},
      '{5'b01001, 32'h0000_0001, 32'h24, 32'h0000_0010},
      '{5'b01000, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF},
      '{5'b00111, 32'h8000_0000, 32'd31, 32'h0000_0001},
      '{5'b00111, 32'hC3A5_0F1E, 32'd0,  32'hC3A5_0F1E},
      '{5'b01001, 32'hC3A5_0F1E, 32'd32, 32'hC3A5_0F1E}
    };
    run_table("shift", t);
  endtask

  task automatic test_compare();
    vec_t t[] = '{
      '{5'b01010, 32'd100,       32'd100, 32'd1},
      '{5'b01010, 32'd100,       32'd99,  32'd0},
      '{5'b01011, 32'd200,       32'd150, 32'd1},
      '{5'b01011, 32'd150,       32'd200, 32'd0},
      '{5'b01100, 32'd50,        32'd100, 32'd1},
      '{5'b01100, 32'd100,       32'd50,  32'd0},
      '{5'b01011, 32'hFFFF_FFFF, 32'd1,   32'd1},
      '{5'b01100, 32'hFFFF_FFFF, 32'd1,   32'd0}
    };
    run_table("compare", t);
  endtask

  task automatic test_undefined();
    vec_t t[] = '{
      '{5'b11111, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0},
      '{5'b00000, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0},
      '{5'b01101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0}
    };
    run_table("undef", t);
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] last;
    n_vec++;
    if (result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle_valid: got %b want 0", result_valid);
    end
    issue(5'b00100, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'hF0F0_F0F0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      last = e;
      if (k == 0)      issue(5'b01001, 32'h0000_0003, 32'd8, 32'h0000_0300);
      else if (k == 1) issue(5'b00001, 32'h1234_5678, 32'h0000_FFFF, 32'h0000_5678);
      else             idle();
      n_vec++;
      if (alu_result !== e || result_valid !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_result[%0d]: got %h/%b want %h/1", k, alu_result, result_valid, e);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (alu_result !== last || result_valid !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_hold[%0d]: got %h/%b want %h/0", k, alu_result, result_valid, last);
      end
      @(negedge clk);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    test_reset();
    test_bitwise();
    test_shift();
    test_compare();
    test_undefined();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_module_logic_alu
`default_nettype wire

// File: doc/module_logic_alu.md
Name: module_logic_alu

Overview:
- Registered logic/shift/compare slice of the ALU: bitwise ops, shifts and comparisons on two WIDTH-bit operands, selected by a 5-bit opcode.
- Sits beside the adder slice; the ALU top muxes its result onto the datapath.
- One-cycle latency; the result is held until the next valid operation.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2, power of two).
- SHW, $clog2(WIDTH) (derived, not overridable), shift-amount width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  operands and opcode valid this cycle.
- alu_a  in  WIDTH  operand A (shift source, compare left side).
- alu_b  in  WIDTH  operand B (shift amount in bits [SHW-1:0], compare right side).
- alu_op  in  5  opcode.
- alu_result  out  WIDTH  registered result.
- result_valid  out  1  alu_result updated by the op issued the previous cycle.

Behaviour:
- Reset (rst_n=0, asynchronous): alu_result=0, result_valid=0 immediately; held until rst_n rises. Reset mid-operation discards the pending op.
- Rising clk with alu_valid=1: alu_result <= f(alu_op, alu_a, alu_b); result_valid <= 1.
- Rising clk with alu_valid=0: alu_result holds; result_valid <= 0.
- Latency exactly 1 cycle. Back-to-back valid ops give one result per cycle. No backpressure.
- Opcodes (5-bit):
  - 00001 AND: a & b.
  - 00010 OR: a | b.
  - 00011 NOT: ~a; b ignored.
  - 00100 XOR: a ^ b.
  - 00101 NAND: ~(a & b).
  - 00110 NOR: ~(a | b).
  - 00111 SRL: a >> b[SHW-1:0], zero fill.
  - 01000 SRA: a >>> b[SHW-1:0], MSB (sign) fill.
  - 01001 SLL: a << b[SHW-1:0], zero fill.
  - 01010 EQ: 1 if a == b, else 0.
  - 01011 GT: 1 if a > b unsigned, else 0.
  - 01100 LT: 1 if a < b unsigned, else 0.
  - All other codes, including 00000 and 11111: result 0.
- Shift width rules:
  - Only b[SHW-1:0] is used; upper bits of b are ignored, so b=WIDTH shifts by 0.
  - Shift by 0 returns a unchanged.
  - SRA by WIDTH-1 yields all copies of the MSB.
- Compare results are zero-extended: bit 0 carries the flag, bits [WIDTH-1:1]=0.
- Combinational next-result logic; no X propagation for undefined opcodes.

Decomposition:
- Shared package alu_pkg:
  - localparam opcode constants (OP_AND … OP_LT, 5-bit, values above).
  - Opcode width constant ALU_OP_W=5, also used by the adder slice and ALU decoder.
- Optional sub-module logic_shifter: combinational SRL/SRA/SLL on (a, shamt, mode).
- Everything else stays inline: opcode case statement plus output register.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> alu_result=0 and result_valid=0 immediately, no clock edge needed; release, idle -> outputs stay 0.
- Bitwise, one cycle after each issue:
  - a=AAAAAAAA, b=FFFF0000: AND -> AAAA0000; OR -> FFFFAAAA; NAND -> 5555FFFF; NOR -> 00005555.
  - a=F0F0F0F0, NOT -> 0F0F0F0F.
  - a=12345678, b=87654321, XOR -> 95511559.
- Shifts, b=4:
  - SLL 0000000F -> 000000F0; SRL F0000000 -> 0F000000.
  - SRA 70000000 -> 07000000; SRA FFFFFF00 -> FFFFFFF0.
  - b=0x24 (only 4 used) SLL 1 -> 00000010.
- Compares:
  - EQ 100,100 -> 1; EQ 100,99 -> 0.
  - GT 200,150 -> 1; LT 50,100 -> 1.
  - GT FFFFFFFF,1 -> 1 (unsigned).
- Undefined op 11111 and op 00000 with nonzero a,b -> 00000000, result_valid=1.
- Handshake: 3 back-to-back valid ops then alu_valid=0 -> three consecutive results, each one cycle after issue; result_valid then drops to 0 and alu_result holds the last value.
